// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, register-index
// width and the hard-wired zero register index.
package pipe_pkg;

  localparam int REG_W = 5;

  localparam logic [REG_W-1:0] ZERO_REG = {REG_W{1'b0}};

  typedef enum logic {
    IDLE    = 1'b0,
    MC_BUSY = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_mc_timer.sv
// Latency counter for multi-cycle EX ops. Loaded with the number of freeze
// cycles when an op starts, decremented once per busy cycle. o_done flags
// the last busy cycle (count of 1).
module hazard_mc_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_done
);

  logic [3:0] r_cnt;

  // Counter register: load on op start, decrement while busy, clear on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_done = (r_cnt == 4'd1);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage core.
// Handles load-use stalls, taken-branch/jump squash and front-end freeze
// while a multi-cycle op occupies EX. All outputs are combinational from
// the FSM state and the current decode/EX inputs.
// Optional build macro HAZARD_STATS_EN adds 32-bit stall and flush counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MC_LAT = 4,
  parameter int REG_W  = pipe_pkg::REG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic             ID_Jump,
  input  logic             ID_MultiCycle,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_Rt,
  input  logic             EX_BranchTaken,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             MCStart,
  output logic             MCBusy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      StallCnt,
  output logic [31:0]      FlushCnt
`endif
);

  // Busy cycles after the start cycle; the start cycle itself lets the
  // front end advance, so the freeze is MC_LAT-1 cycles.
  localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 1);

  hz_state_t r_state;
  hz_state_t w_next;
  logic      w_lu;
  logic      w_load;
  logic      w_dec;
  logic      w_done;

  // Load-use: a load in EX writes a register the ID instruction reads.
  // Loads to the zero register never create a dependency.
  assign w_lu = EX_MemRead && (EX_Rt != ZERO_REG) &&
                ((ID_UseRs && (ID_Rs == EX_Rt)) || (ID_UseRt && (ID_Rt == EX_Rt)));

  hazard_mc_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (MC_LOAD),
    .i_dec      (w_dec),
    .o_done     (w_done)
  );

  // State register; reset aborts any multi-cycle op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and pipeline control outputs, prioritised branch > load-use > jump > MC start.
  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    MCStart   = 1'b0;
    MCBusy    = 1'b0;
    w_next    = r_state;
    w_load    = 1'b0;
    w_dec     = 1'b0;
    if (reset) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
      w_next    = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (EX_BranchTaken) begin
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
          end else if (w_lu) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
          end else if (ID_Jump) begin
            IFIDFlush = 1'b1;
          end else if (ID_MultiCycle) begin
            MCStart = 1'b1;
            if (MC_LAT > 1) begin
              w_next = MC_BUSY;
              w_load = 1'b1;
            end else begin
              w_next = IDLE;
            end
          end else begin
            w_next = IDLE;
          end
        end
        MC_BUSY: begin
          // EX holds bubbles here, so decode and branch inputs are ignored.
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          IDEXFlush = 1'b1;
          MCBusy    = 1'b1;
          w_dec     = 1'b1;
          if (w_done) begin
            w_next = IDLE;
          end else begin
            w_next = MC_BUSY;
          end
        end
        default: begin
          w_next = IDLE;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Event counters for stall and flush cycles; reset cycles are not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      r_stall_cnt <= r_stall_cnt + {31'd0, ~PCWrite};
      r_flush_cnt <= r_flush_cnt + {31'd0, IFIDFlush};
    end
  end

  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (MC_LAT=4). Outputs are checked as a
// packed vector {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MCStart, MCBusy}.
// Build with HAZARD_STATS_EN to also check the stall/flush counters.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_Rs, ID_Rt, EX_Rt;
  logic       ID_UseRs, ID_UseRt, ID_Jump, ID_MultiCycle;
  logic       EX_MemRead, EX_BranchTaken;
  logic       PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MCStart, MCBusy;
`ifdef HAZARD_STATS_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] outs;
  assign outs = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MCStart, MCBusy};

  localparam logic [5:0] O_RST    = 6'b001100;
  localparam logic [5:0] O_NORM   = 6'b110000;
  localparam logic [5:0] O_LU     = 6'b000100;
  localparam logic [5:0] O_JUMP   = 6'b111000;
  localparam logic [5:0] O_BRANCH = 6'b111100;
  localparam logic [5:0] O_MCST   = 6'b110010;
  localparam logic [5:0] O_BUSY   = 6'b000101;

  hazard_ctrl #(.MC_LAT(4), .REG_W(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .ID_UseRs       (ID_UseRs),
    .ID_UseRt       (ID_UseRt),
    .ID_Jump        (ID_Jump),
    .ID_MultiCycle  (ID_MultiCycle),
    .EX_MemRead     (EX_MemRead),
    .EX_Rt          (EX_Rt),
    .EX_BranchTaken (EX_BranchTaken),
    .PCWrite        (PCWrite),
    .IFIDWrite      (IFIDWrite),
    .IFIDFlush      (IFIDFlush),
    .IDEXFlush      (IDEXFlush),
    .MCStart        (MCStart),
    .MCBusy         (MCBusy)
`ifdef HAZARD_STATS_EN
    ,
    .StallCnt       (StallCnt),
    .FlushCnt       (FlushCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic idle_inputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; EX_Rt = 5'd0;
    ID_UseRs = 1'b0; ID_UseRt = 1'b0; ID_Jump = 1'b0; ID_MultiCycle = 1'b0;
    EX_MemRead = 1'b0; EX_BranchTaken = 1'b0;
  endtask

  // Check outputs mid-cycle, then move to just after the next rising edge.
  task automatic expect_outs(input string tag, input logic [5:0] expv);
    @(negedge clk);
    chk(tag, {26'd0, outs}, {26'd0, expv});
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    expect_outs("reset_outs", O_RST);
    reset = 1'b0;
    expect_outs("normal_after_reset", O_NORM);

    // Test 1: load-use on Rs -> exactly one stall cycle
    EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8; ID_UseRs = 1'b1;
    expect_outs("lu_rs_stall", O_LU);
    idle_inputs();
    expect_outs("lu_released", O_NORM);

    // Test 2: load to $0 never stalls
    EX_MemRead = 1'b1; EX_Rt = 5'd0; ID_Rs = 5'd0; ID_UseRs = 1'b1;
    expect_outs("lu_zero_reg", O_NORM);
    idle_inputs();

    // Test 3: branch taken beats load-use
    EX_BranchTaken = 1'b1;
    EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8; ID_UseRs = 1'b1;
    expect_outs("branch_over_lu", O_BRANCH);
    idle_inputs();

    // Test 4: multi-cycle op, start pulse then 3 busy cycles
    ID_MultiCycle = 1'b1;
    expect_outs("mc_start", O_MCST);
    idle_inputs();
    expect_outs("mc_busy1", O_BUSY);
    EX_BranchTaken = 1'b1;
    expect_outs("mc_busy2_ignores_br", O_BUSY);
    idle_inputs();
    expect_outs("mc_busy3", O_BUSY);
    expect_outs("mc_back_idle", O_NORM);
`ifdef HAZARD_STATS_EN
    chk("stall_cnt_t134", StallCnt, 32'd4);
    chk("flush_cnt_t134", FlushCnt, 32'd1);
`endif

    // Further load-use and priority vectors
    EX_MemRead = 1'b1; EX_Rt = 5'd12; ID_Rt = 5'd12; ID_UseRt = 1'b1;
    expect_outs("lu_rt_stall", O_LU);
    ID_UseRt = 1'b0;
    expect_outs("lu_rt_unused", O_NORM);
    EX_MemRead = 1'b0; ID_UseRt = 1'b1;
    expect_outs("no_load_no_stall", O_NORM);
    idle_inputs();
    EX_MemRead = 1'b1; EX_Rt = 5'd3; ID_Rs = 5'd3; ID_UseRs = 1'b1; ID_Jump = 1'b1;
    expect_outs("lu_over_jump", O_LU);
    idle_inputs();
    ID_Jump = 1'b1;
    expect_outs("jump_flush", O_JUMP);
    idle_inputs();
    EX_BranchTaken = 1'b1; ID_MultiCycle = 1'b1;
    expect_outs("branch_suppresses_mc", O_BRANCH);
    idle_inputs();
    expect_outs("no_busy_after_br_mc", O_NORM);
    EX_MemRead = 1'b1; EX_Rt = 5'd9; ID_Rs = 5'd9; ID_UseRs = 1'b1; ID_MultiCycle = 1'b1;
    expect_outs("lu_suppresses_mc", O_LU);
    idle_inputs();
    expect_outs("no_busy_after_lu_mc", O_NORM);

    // Back-to-back MC ops: second starts on first IDLE cycle
    ID_MultiCycle = 1'b1;
    expect_outs("b2b_start1", O_MCST);
    expect_outs("b2b_busy1", O_BUSY);
    expect_outs("b2b_busy2", O_BUSY);
    expect_outs("b2b_busy3", O_BUSY);
    expect_outs("b2b_start2", O_MCST);
    idle_inputs();
    expect_outs("b2b2_busy1", O_BUSY);
    expect_outs("b2b2_busy2", O_BUSY);
    expect_outs("b2b2_busy3", O_BUSY);
    expect_outs("b2b2_idle", O_NORM);

    // Test 5: reset during the 2nd busy cycle aborts the op
    ID_MultiCycle = 1'b1;
    expect_outs("t5_start", O_MCST);
    idle_inputs();
    expect_outs("t5_busy1", O_BUSY);
    reset = 1'b1;
    expect_outs("t5_reset_forced", O_RST);
    reset = 1'b0;
    expect_outs("t5_idle_after_reset", O_NORM);
    expect_outs("t5_still_idle", O_NORM);
`ifdef HAZARD_STATS_EN
    chk("stall_cnt_cleared", StallCnt, 32'd0);
    chk("flush_cnt_cleared", FlushCnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
